// File: rtl/snitch_icache_pkg.sv
// Shared configuration and types for the L0-to-L1 instruction refill path.
package snitch_icache_pkg;

  typedef struct packed {
    int unsigned NR_PORTS;
    int unsigned PENDING;
    int unsigned FETCH_AW;
    int unsigned LINE_WIDTH;
  } config_t;

  localparam config_t DefaultCfg = '{
    NR_PORTS:   4,
    PENDING:    4,
    FETCH_AW:   32,
    LINE_WIDTH: 128
  };

  // Each L0 owns a demand bit and a prefetch bit in the requester ID.
  localparam int unsigned RefillIdW = 2 * DefaultCfg.NR_PORTS;

  // One in-flight refill: the line address and every L0 waiting for it.
  typedef struct packed {
    logic                         vld;
    logic [DefaultCfg.FETCH_AW-1:0] addr;
    logic [RefillIdW-1:0]         idmask;
  } refill_entry_t;

  // Index width that stays legal for a single-element range.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snitch_icache_refill_table.sv
// In-flight refill table: address match for coalescing, lowest-free
// allocation, and release on the L1 response handshake.
module snitch_icache_refill_table
  import snitch_icache_pkg::*;
#(
  parameter int unsigned FETCH_AW = DefaultCfg.FETCH_AW,
  parameter int unsigned ID_WIDTH = RefillIdW,
  parameter int unsigned PENDING  = DefaultCfg.PENDING,
  localparam int unsigned IdxW    = idx_width(PENDING)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [FETCH_AW-1:0] lookup_addr_i,
  input  logic [ID_WIDTH-1:0] lookup_id_i,
  output logic                hit_o,
  output logic                free_avail_o,
  output logic [IdxW-1:0]     alloc_idx_o,
  input  logic                merge_i,
  input  logic                alloc_i,
  input  logic [IdxW-1:0]     rsp_idx_i,
  input  logic                free_i,
  output logic                rsp_vld_o,
  output logic [ID_WIDTH-1:0] rsp_idmask_o
);

  logic [PENDING-1:0]  vld_q;
  logic [FETCH_AW-1:0] addr_q   [PENDING];
  logic [ID_WIDTH-1:0] idmask_q [PENDING];
  logic [PENDING-1:0]  match;
  logic [IdxW-1:0]     hit_idx;

  // An entry released this cycle no longer absorbs new requesters.
  for (genvar gi = 0; gi < PENDING; gi++) begin : g_match
    assign match[gi] = vld_q[gi] && (addr_q[gi] == lookup_addr_i) &&
                       !(free_i && (rsp_idx_i == IdxW'(gi)));
  end

  assign hit_o        = |match;
  assign free_avail_o = ~&vld_q;
  assign rsp_vld_o    = vld_q[rsp_idx_i];
  assign rsp_idmask_o = vld_q[rsp_idx_i] ? idmask_q[rsp_idx_i] : '0;

  // Encode the matching entry and the lowest-numbered free entry.
  always_comb begin
    hit_idx     = '0;
    alloc_idx_o = '0;
    for (int e = 0; e < PENDING; e++) begin
      if (match[e]) hit_idx = IdxW'(e);
    end
    for (int e = PENDING - 1; e >= 0; e--) begin
      if (!vld_q[e]) alloc_idx_o = IdxW'(e);
    end
  end

  // Table update: free on response, fill on allocate, OR in merged IDs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int e = 0; e < PENDING; e++) begin
        addr_q[e]   <= '0;
        idmask_q[e] <= '0;
      end
    end else begin
      if (free_i) vld_q[rsp_idx_i] <= 1'b0;
      if (alloc_i) begin
        vld_q[alloc_idx_o]    <= 1'b1;
        addr_q[alloc_idx_o]   <= lookup_addr_i;
        idmask_q[alloc_idx_o] <= lookup_id_i;
      end
      if (merge_i) idmask_q[hit_idx] <= idmask_q[hit_idx] | lookup_id_i;
    end
  end

  // Addresses of live entries are unique, so at most one can match.
  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(match));

endmodule

// File: rtl/snitch_icache_refill_merge.sv
// Refill front-end: round-robin over the L0 ports, coalesce duplicate line
// requests, issue one L1 lookup per new line and broadcast the response.
module snitch_icache_refill_merge
  import snitch_icache_pkg::*;
#(
  parameter int unsigned NR_PORTS   = DefaultCfg.NR_PORTS,
  parameter int unsigned FETCH_AW   = DefaultCfg.FETCH_AW,
  parameter int unsigned LINE_WIDTH = DefaultCfg.LINE_WIDTH,
  parameter int unsigned ID_WIDTH   = 2 * NR_PORTS,
  parameter int unsigned PENDING    = DefaultCfg.PENDING,
  localparam int unsigned IdxW      = idx_width(PENDING),
  localparam int unsigned PortW     = idx_width(NR_PORTS)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NR_PORTS-1:0][FETCH_AW-1:0]  in_req_addr_i,
  input  logic [NR_PORTS-1:0][ID_WIDTH-1:0]  in_req_id_i,
  input  logic [NR_PORTS-1:0]                in_req_valid_i,
  output logic [NR_PORTS-1:0]                in_req_ready_o,
  output logic [LINE_WIDTH-1:0]              in_rsp_data_o,
  output logic                               in_rsp_error_o,
  output logic [ID_WIDTH-1:0]                in_rsp_id_o,
  output logic [NR_PORTS-1:0]                in_rsp_valid_o,
  input  logic [NR_PORTS-1:0]                in_rsp_ready_i,
  output logic [FETCH_AW-1:0]                out_req_addr_o,
  output logic [IdxW-1:0]                    out_req_id_o,
  output logic                               out_req_valid_o,
  input  logic                               out_req_ready_i,
  input  logic [LINE_WIDTH-1:0]              out_rsp_data_i,
  input  logic                               out_rsp_error_i,
  input  logic [IdxW-1:0]                    out_rsp_id_i,
  input  logic                               out_rsp_valid_i,
  output logic                               out_rsp_ready_o
);

  logic [PortW-1:0]    rr_q, gnt_idx;
  logic                gnt_valid, hit, free_avail, merge, alloc, req_hs;
  logic [IdxW-1:0]     alloc_idx;
  logic                out_valid_q;
  logic [FETCH_AW-1:0] out_addr_q;
  logic [IdxW-1:0]     out_id_q;
  logic                rsp_vld, rsp_free;
  logic [ID_WIDTH-1:0] rsp_idmask;
  logic [NR_PORTS-1:0] rsp_tgt;

  // Round-robin grant: first valid port at or after the pointer.
  always_comb begin
    logic [PortW-1:0] cand;
    cand      = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int off = NR_PORTS - 1; off >= 0; off--) begin
      cand = PortW'((int'(rr_q) + off) % NR_PORTS);
      if (in_req_valid_i[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // A new line may only claim the output register if it is free or draining.
  assign merge  = gnt_valid & hit;
  assign alloc  = gnt_valid & ~hit & free_avail & (~out_valid_q | out_req_ready_i);
  assign req_hs = merge | alloc;

  snitch_icache_refill_table #(
    .FETCH_AW (FETCH_AW),
    .ID_WIDTH (ID_WIDTH),
    .PENDING  (PENDING)
  ) i_table (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .lookup_addr_i (in_req_addr_i[gnt_idx]),
    .lookup_id_i   (in_req_id_i[gnt_idx]),
    .hit_o         (hit),
    .free_avail_o  (free_avail),
    .alloc_idx_o   (alloc_idx),
    .merge_i       (merge),
    .alloc_i       (alloc),
    .rsp_idx_i     (out_rsp_id_i),
    .free_i        (rsp_free),
    .rsp_vld_o     (rsp_vld),
    .rsp_idmask_o  (rsp_idmask)
  );

  // Per-port request ready and response fan-out from the entry's ID mask.
  for (genvar gi = 0; gi < NR_PORTS; gi++) begin : g_port
    assign in_req_ready_o[gi] = req_hs && (gnt_idx == PortW'(gi));
    assign rsp_tgt[gi]        = |rsp_idmask[2*gi +: 2];
    assign in_rsp_valid_o[gi] = out_rsp_valid_i & rsp_tgt[gi];
  end

  // Untargeted ports never hold back the response; stale ones drain freely.
  assign out_rsp_ready_o = &(~rsp_tgt | in_rsp_ready_i);
  assign rsp_free        = out_rsp_valid_i & out_rsp_ready_o & rsp_vld;
  assign in_rsp_data_o   = out_rsp_data_i;
  assign in_rsp_error_o  = out_rsp_error_i;
  assign in_rsp_id_o     = rsp_idmask;

  assign out_req_addr_o  = out_addr_q;
  assign out_req_id_o    = out_id_q;
  assign out_req_valid_o = out_valid_q;

  // Grant pointer moves past the winner on handshake; output register holds
  // an allocated line until L1 takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_id_q    <= '0;
    end else begin
      if (req_hs) begin
        rr_q <= (gnt_idx == PortW'(NR_PORTS - 1)) ? '0 : gnt_idx + PortW'(1);
      end
      if (alloc) begin
        out_valid_q <= 1'b1;
        out_addr_q  <= in_req_addr_i[gnt_idx];
        out_id_q    <= alloc_idx;
      end else if (out_req_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < NR_PORTS; gi++) begin : g_id_chk
    assert property (@(posedge clk_i) disable iff (!rst_ni)
      in_req_valid_i[gi] |-> $onehot(in_req_id_i[gi]));
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid_q && !out_req_ready_i) |=>
      (out_valid_q && $stable(out_addr_q) && $stable(out_id_q)));

endmodule
